regfile_debug_port: RTL

//   Debug-side initiator for the 32x32 RV32I register file. Accepts read/write/dump commands

---
 rtl/regfile_debug_port_pkg.sv | 19 +
 rtl/regfile_debug_port_mux.sv | 20 ++
 rtl/regfile_debug_port.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_debug_port_pkg.sv
// regfile_debug_port_pkg: shared op/state encodings and register-file geometry
package regfile_debug_port_pkg;
   localparam int NUM_REGS = 32;
   localparam logic [4:0] IDX_LAST = 5'(NUM_REGS - 1);
   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_DUMP  = 2'b10,
      OP_ILL   = 2'b11
   } op_t;
   typedef enum logic [2:0] {
      IDLE,
      HALT_WAIT,
      EXEC,
      RESP,
      DUMP_RD,
      DUMP_RESP
   } state_t;
endpackage

// File: rtl/regfile_debug_port_mux.sv
// regfile_debug_port_mux: regfile write-port ownership mux, core vs debug
module regfile_debug_port_mux (
   input  logic        own,
   input  logic        dbg_we,
   input  logic [4:0]  dbg_rd,
   input  logic [31:0] dbg_wd,
   input  logic        core_we,
   input  logic [4:0]  core_rd,
   input  logic [31:0] core_wd,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wd
);
   // core writes arriving while debug owns the port are dropped
   always_comb begin
      rf_we = own ? dbg_we : core_we;
      rf_rd = own ? dbg_rd : core_rd;
      rf_wd = own ? dbg_wd : core_wd;
   end
endmodule

// File: rtl/regfile_debug_port.sv
// regfile_debug_port: debug initiator that halts the core and reads, writes
// or dumps the RV32I register file over valid/ready command/response channels
module regfile_debug_port
   import regfile_debug_port_pkg::*;
#(
   parameter int HALT_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_last,
   output logic        core_halt_req,
   input  logic        core_halted,
   input  logic        core_we,
   input  logic [4:0]  core_rd,
   input  logic [31:0] core_wd,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wd,
   output logic [4:0]  rf_rs,
   input  logic [31:0] rf_rdata
);
   localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
   state_t state, next;
   op_t op_q;
   logic [4:0] addr_q, idx;
   logic [31:0] wdata_q;
   logic [CNT_W-1:0] cnt;
   logic timeout, own, dbg_we;
   assign timeout = cnt == CNT_W'(HALT_TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= next;
   end
   always_comb begin
      next = state;
      unique case (state)
         IDLE:      if (cmd_valid) next = (op_t'(cmd_op) == OP_ILL) ? RESP : HALT_WAIT;
         HALT_WAIT: if (core_halted) next = (op_q == OP_DUMP) ? DUMP_RD : EXEC;
                    else if (timeout) next = RESP;
         EXEC:      next = RESP;
         RESP:      if (rsp_ready) next = IDLE;
         DUMP_RD:   next = DUMP_RESP;
         DUMP_RESP: if (rsp_ready) next = (idx == IDX_LAST) ? IDLE : DUMP_RD;
         default:   next = IDLE;
      endcase
   end
   always_comb begin
      cmd_ready = !rst && state == IDLE;
      rsp_valid = state == RESP || state == DUMP_RESP;
      own = state == EXEC || state == DUMP_RD;
      dbg_we = state == EXEC && op_q == OP_WRITE && addr_q != 5'd0;
      rf_rs = (state == DUMP_RD) ? idx : addr_q;
   end
   // response registers, halt request, timeout counter and dump index
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= OP_READ;
         addr_q <= '0;
         wdata_q <= '0;
         idx <= '0;
         cnt <= '0;
         core_halt_req <= 1'b0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
         rsp_last <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (cmd_valid) begin
               op_q <= op_t'(cmd_op);
               addr_q <= cmd_addr;
               wdata_q <= cmd_wdata;
               cnt <= '0;
               if (op_t'(cmd_op) == OP_ILL) begin
                  rsp_rdata <= '0;
                  rsp_err <= 1'b1;
                  rsp_last <= 1'b1;
               end else core_halt_req <= 1'b1;
            end
            HALT_WAIT: if (core_halted) idx <= '0;
               else if (timeout) begin
                  core_halt_req <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err <= 1'b1;
                  rsp_last <= 1'b1;
               end else cnt <= cnt + CNT_W'(1);
            EXEC: begin
               rsp_rdata <= (op_q == OP_READ) ? rf_rdata : 32'd0;
               rsp_err <= 1'b0;
               rsp_last <= 1'b1;
            end
            RESP: if (rsp_ready) core_halt_req <= 1'b0;
            DUMP_RD: begin
               rsp_rdata <= rf_rdata;
               rsp_err <= 1'b0;
               rsp_last <= idx == IDX_LAST;
            end
            DUMP_RESP: if (rsp_ready) begin
               if (idx == IDX_LAST) core_halt_req <= 1'b0;
               else idx <= idx + 5'd1;
            end
            default: ;
         endcase
      end
   end
   regfile_debug_port_mux u_mux (
      .own     (own),
      .dbg_we  (dbg_we),
      .dbg_rd  (addr_q),
      .dbg_wd  (wdata_q),
      .core_we (core_we),
      .core_rd (core_rd),
      .core_wd (core_wd),
      .rf_we   (rf_we),
      .rf_rd   (rf_rd),
      .rf_wd   (rf_wd)
   );
endmodule
